conv_layer_sequencer: RTL and testbench
=======================================

# conv_layer_sequencer

Frame-level controller in front of `conv_pooling_layer`. It accepts an upstream pixel stream with a valid/ready handshake. It paces pixels into the layer at no more than one every `CyclesPerPixel` cycles, which is the rate at which the layer's shared processing elements can cover all `NumberOfK` kernels. After the last pixel of an `ImageWidth`×`ImageWidth` frame it waits for the layer's pooling to finish, then reports frame completion. A drain timeout flags a hung layer.

## Interface

**Parameters**

- `BitSize`, 8: pixel width.
- `ImageWidth`, 16: frame side length; `ImageWidth*ImageWidth` pixels per frame.
- `NumberOfK`, 8: number of kernels in the driven layer.
- `ProcessingElements`, 2: processing elements in the driven layer.
- `CyclesPerPixel`, `NumberOfK/ProcessingElements`: minimum spacing, in cycles, between pixels issued to the layer. Must be ≥1.
- `DrainTimeout`, 1024: maximum number of DRAIN cycles before an error is raised.

**Ports** (clock and reset first)

- `clk`, in, 1: single clock; all logic is on the rising edge.
- `res_n`, in, 1: reset. Synchronous, active-high: 1 resets the block at the next `clk` edge.
- `start`, in, 1: one-cycle pulse that begins a frame. Ignored outside IDLE.
- `up_valid`, in, 1: upstream pixel valid.
- `up_data`, in, `BitSize`: upstream pixel.
- `up_ready`, out, 1: sequencer can accept a pixel this cycle.
- `layer_in_valid`, out, 1: drives `conv_pooling_layer.in_valid`.
- `layer_in_data`, out, `BitSize`: drives `conv_pooling_layer.in_data`.
- `layer_pooling_done`, in, 1: from `conv_pooling_layer.pooling_done`.
- `busy`, out, 1: high in FEED and DRAIN.
- `frame_done`, out, 1: one-cycle pulse when a frame completes.
- `error`, out, 1: drain timeout occurred. Sticky.
- `frame_count`, out, 16: number of completed frames; wraps modulo 2^16.

## Operation

**States:** IDLE, FEED, DRAIN, DONE, ERR.

- **IDLE**
  - `up_ready`=0, `busy`=0.
  - `start` → FEED. On entry, `pix_cnt`=0 and `slot`=0.
- **FEED**
  - `busy`=1.
  - `up_ready` = (`slot`==0). This is combinational from `slot`, not from `up_valid`.
  - A transfer occurs when `up_valid`&&`up_ready`. On a transfer:
    - `layer_in_data` ← `up_data`.
    - `pix_cnt`++.
    - `slot` ← `CyclesPerPixel`-1.
  - When `slot`≠0 it decrements by 1 every cycle, whether or not `up_valid` is high.
  - A transfer with `pix_cnt`==`ImageWidth*ImageWidth`-1 → DRAIN.
- **DRAIN**
  - `up_ready`=0, `busy`=1.
  - On entry, `tmo`=0; `tmo` increments every DRAIN cycle.
  - A rising edge of `layer_pooling_done` (current=1, previous=0, previous value held in a register) → DONE.
  - `tmo`==`DrainTimeout`-1 with no rising edge → ERR.
  - A rising edge in that same final cycle wins: → DONE.
- **DONE**
  - `frame_done`=1 for exactly this one cycle.
  - `frame_count`++.
  - → IDLE.
- **ERR**
  - `error`=1, `up_ready`=0, `busy`=0.
  - `start` is ignored. The only exit is reset.

**Widths:** `pix_cnt` is `$clog2(ImageWidth*ImageWidth+1)` bits; `slot` is `$clog2(CyclesPerPixel+1)` bits; `tmo` is `$clog2(DrainTimeout+1)` bits.

**Boundary conditions**

- `CyclesPerPixel`=1: `slot` stays 0, so back-to-back transfers every cycle are allowed.
- `layer_pooling_done` still high from the previous frame does not complete the new frame. Only a 0→1 edge seen while in DRAIN counts.
- `start` in the same cycle as DONE is ignored; a new `start` must arrive while in IDLE.
- Reset mid-frame:
  - → IDLE; all counters clear; `frame_count`=0; `error`=0.
  - `layer_in_valid`=0 from the first post-reset cycle.
  - The layer must be reset together with the sequencer.

## Timing

- **Reset values:** `up_ready`=0, `layer_in_valid`=0, `layer_in_data`=0, `busy`=0, `frame_done`=0, `error`=0, `frame_count`=0, state=IDLE.
- **`start` → FEED:** FEED is entered on the edge after `start`. `up_ready` can be 1 in the first FEED cycle.
- **Transfer latency:** for a transfer in cycle t, `layer_in_valid`=1 in cycle t+1 only, with `layer_in_data` valid in t+1. `layer_in_data` then holds its value until the next transfer.
- **Issue spacing:** consecutive `layer_in_valid` pulses are ≥`CyclesPerPixel` cycles apart, and exactly `CyclesPerPixel` apart when `up_valid` is held high.
- **Last pixel → DRAIN:** DRAIN is entered in cycle t+1 after the last transfer in cycle t.
- **Edge → `frame_done`:** a `layer_pooling_done` edge in DRAIN cycle d gives `frame_done`=1 in cycle d+1. `busy` falls in that same cycle d+1.
- **`frame_count` update:** `frame_count` shows the new value in cycle d+2.

## Test plan

For all cases, `ImageWidth`=4 (16 pixels), `CyclesPerPixel`=4, `DrainTimeout`=32 unless stated otherwise.

1. **Reset:** assert `res_n`=1 for 2 cycles → all outputs at their reset values; `up_ready`=0 even with `up_valid`=1.
2. **Full-rate frame:** `start`, then `up_valid` held high with `up_data`=0..15 → 16 `layer_in_valid` pulses exactly 4 cycles apart carrying 0..15 in order; DRAIN entered after the 16th transfer; `up_ready`=0 from then on.
3. **Upstream bubble:** drop `up_valid` for 6 cycles after pixel 5 → pixel 6 is accepted in the first cycle `up_valid` returns (`slot` already 0); no pixel is lost or duplicated.
4. **Normal completion:** `layer_pooling_done` rises 10 cycles into DRAIN → `frame_done` pulses once the next cycle; `frame_count`=1; `busy`=0. A second frame then completes with `frame_count`=2.
5. **Stale done level:** hold `layer_pooling_done`=1 through FEED into DRAIN → no completion; drop it to 0, then raise it → `frame_done` follows the rising edge.
6. **Timeout and mid-frame reset:**
   - Timeout: no rising edge on `layer_pooling_done` → `error`=1 after 32 DRAIN cycles; a later `start` is ignored.
   - Mid-frame reset: assert reset after 7 pixels of a fresh frame → IDLE, counters 0; a following `start` runs a full 16-pixel frame.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
// Frame-level controller in front of conv_pooling_layer. Accepts an upstream
// pixel stream (valid/ready), paces pixels into the layer no faster than one
// every CyclesPerPixel cycles, waits for the layer's pooling to finish after
// the last pixel of a frame, then pulses frame_done. A drain watchdog parks
// the block in a sticky error state if the layer never finishes.

module conv_layer_sequencer #(
    parameter int BitSize            = 8,
    parameter int ImageWidth         = 16,
    parameter int NumberOfK          = 8,
    parameter int ProcessingElements = 2,
    parameter int CyclesPerPixel     = NumberOfK / ProcessingElements,
    parameter int DrainTimeout       = 1024
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               start,
    input  logic               up_valid,
    input  logic [BitSize-1:0] up_data,
    output logic               up_ready,
    output logic               layer_in_valid,
    output logic [BitSize-1:0] layer_in_data,
    input  logic               layer_pooling_done,
    output logic               busy,
    output logic               frame_done,
    output logic               error,
    output logic [15:0]        frame_count
);

    localparam int NumPixels = ImageWidth * ImageWidth;
    localparam int PixW      = $clog2(NumPixels + 1);
    localparam int SlotW     = $clog2(CyclesPerPixel + 1);
    localparam int TmoW      = $clog2(DrainTimeout + 1);

    localparam logic [PixW-1:0]  LastPix    = PixW'(NumPixels - 1);
    localparam logic [SlotW-1:0] SlotReload = SlotW'(CyclesPerPixel - 1);
    localparam logic [TmoW-1:0]  TmoLast    = TmoW'(DrainTimeout - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // A completion only counts on a fresh 0->1 transition, so a level left
    // high from the previous frame cannot finish the next one.
    function automatic logic rising_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

    state_t             state_q, state_d;
    logic [PixW-1:0]    pix_cnt_q, pix_cnt_d;
    logic [SlotW-1:0]   slot_q, slot_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               pd_prev_q;
    logic               in_valid_q, in_valid_d;
    logic [BitSize-1:0] in_data_q, in_data_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               error_q, error_d;

    logic               xfer_s;
    logic               pd_rise_s;

    // Ready depends only on the pacing slot, never on up_valid, so upstream
    // can't form a combinational loop through this block.
    assign up_ready  = (state_q == ST_FEED) && (slot_q == {SlotW{1'b0}});
    assign xfer_s    = up_valid && up_ready;
    assign pd_rise_s = rising_edge(layer_pooling_done, pd_prev_q);

    assign layer_in_valid = in_valid_q;
    assign layer_in_data  = in_data_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign error          = error_q;
    assign frame_count    = frame_count_q;

    // Next-state, counter and datapath decode for the frame FSM.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        slot_d        = slot_q;
        tmo_d         = tmo_q;
        in_valid_d    = 1'b0;
        in_data_d     = in_data_q;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FEED;
                    pix_cnt_d = {PixW{1'b0}};
                    slot_d    = {SlotW{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_FEED: begin
                if (xfer_s) begin
                    in_valid_d = 1'b1;
                    in_data_d  = up_data;
                    pix_cnt_d  = pix_cnt_q + PixW'(1);
                    slot_d     = SlotReload;
                    if (pix_cnt_q == LastPix) begin
                        state_d = ST_DRAIN;
                        tmo_d   = {TmoW{1'b0}};
                    end else begin
                        state_d = ST_FEED;
                    end
                end else if (slot_q != {SlotW{1'b0}}) begin
                    // Pacing slot runs down whether or not upstream is offering.
                    slot_d = slot_q - SlotW'(1);
                end else begin
                    slot_d = slot_q;
                end
            end

            ST_DRAIN: begin
                tmo_d = tmo_q + TmoW'(1);
                // An edge in the watchdog's final cycle still completes the frame.
                if (pd_rise_s) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TmoLast) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                // start is deliberately not sampled here.
                frame_count_d = frame_count_q + 16'd1;
                state_d       = ST_IDLE;
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with it.
    always_comb begin
        busy_d       = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        frame_done_d = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
    end

    // State, counters and registered outputs; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (res_n) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= {PixW{1'b0}};
            slot_q        <= {SlotW{1'b0}};
            tmo_q         <= {TmoW{1'b0}};
            pd_prev_q     <= 1'b0;
            in_valid_q    <= 1'b0;
            in_data_q     <= {BitSize{1'b0}};
            frame_count_q <= 16'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            slot_q        <= slot_d;
            tmo_q         <= tmo_d;
            pd_prev_q     <= layer_pooling_done;
            in_valid_q    <= in_valid_d;
            in_data_q     <= in_data_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: 16-pixel frames at 4 cycles per
// pixel, a 32-cycle drain watchdog, and a scoreboard of pixels in flight.

module tb_conv_layer_sequencer;

    localparam int BW  = 8;
    localparam int CPP = 4;

    logic          clk;
    logic          res_n;
    logic          start;
    logic          up_valid;
    logic [BW-1:0] up_data;
    logic          up_ready;
    logic          layer_in_valid;
    logic [BW-1:0] layer_in_data;
    logic          layer_pooling_done;
    logic          busy;
    logic          frame_done;
    logic          error;
    logic [15:0]   frame_count;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [BW-1:0] sb[$];
    logic          exact_mode = 1'b0;
    logic          have_prev  = 1'b0;
    int            last_cyc   = 0;

    conv_layer_sequencer #(
        .BitSize           (BW),
        .ImageWidth        (4),
        .NumberOfK         (8),
        .ProcessingElements(2),
        .DrainTimeout      (32)
    ) dut (
        .clk               (clk),
        .res_n             (res_n),
        .start             (start),
        .up_valid          (up_valid),
        .up_data           (up_data),
        .up_ready          (up_ready),
        .layer_in_valid    (layer_in_valid),
        .layer_in_data     (layer_in_data),
        .layer_pooling_done(layer_pooling_done),
        .busy              (busy),
        .frame_done        (frame_done),
        .error             (error),
        .frame_count       (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pop/compare issued pixels, check spacing, push accepted ones.
    always @(negedge clk) begin
        if (layer_in_valid === 1'b1) begin
            chk("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("pix_data", 32'(layer_in_data), 32'(sb.pop_front()));
            if (have_prev) begin
                chk("gap_min", 32'((cyc - last_cyc) >= CPP), 32'd1);
                if (exact_mode) chk("gap_exact", 32'(cyc - last_cyc), 32'(CPP));
            end
            have_prev = 1'b1;
            last_cyc  = cyc;
        end
        if (busy !== 1'b1) have_prev = 1'b0;
        if (res_n === 1'b0 && up_valid === 1'b1 && up_ready === 1'b1) sb.push_back(up_data);
    end

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("feed_entry_busy", 32'(busy), 32'd1);
        chk("feed_entry_ready", 32'(up_ready), 32'd1);
    endtask

    // Offer n pixels base, base+1, ...; optional 6-cycle bubble after bubble_at pixels.
    task automatic feed(input int n, input int base, input int bubble_at);
        int sent;
        int guard;
        logic x;
        sent     = 0;
        guard    = 0;
        up_valid = 1'b1;
        up_data  = BW'(base);
        while (sent < n && guard < 500) begin
            x = up_valid && up_ready;
            tick();
            guard++;
            if (x) begin
                sent++;
                up_data = BW'(base + sent);
                if (sent == bubble_at) begin
                    up_valid = 1'b0;
                    repeat (6) tick();
                    up_valid = 1'b1;
                    chk("bubble_ready", 32'(up_ready), 32'd1);
                end
            end
        end
        up_valid = 1'b0;
        chk("feed_count", 32'(sent), 32'(n));
    endtask

    initial begin
        res_n              = 1'b1;
        start              = 1'b0;
        up_valid           = 1'b1;
        up_data            = 8'd0;
        layer_pooling_done = 1'b0;

        // Reset values, with up_valid asserted
        tick();
        tick();
        chk("rst_up_ready", 32'(up_ready), 32'd0);
        chk("rst_in_valid", 32'(layer_in_valid), 32'd0);
        chk("rst_in_data", 32'(layer_in_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        up_valid = 1'b0;
        res_n    = 1'b0;
        tick();

        // Frame A: full rate, then completion 10 cycles into DRAIN
        exact_mode = 1'b1;
        start_frame();
        feed(16, 0, 0);
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_ready", 32'(up_ready), 32'd0);
        up_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("drain_ready_hold", 32'(up_ready), 32'd0);
        end
        up_valid = 1'b0;
        repeat (6) tick();
        layer_pooling_done = 1'b1;
        chk("a_pre_done", 32'(frame_done), 32'd0);
        tick();
        chk("a_frame_done", 32'(frame_done), 32'd1);
        chk("a_busy_fall", 32'(busy), 32'd0);
        chk("a_count_old", 32'(frame_count), 32'd0);
        tick();
        chk("a_done_pulse", 32'(frame_done), 32'd0);
        chk("a_count", 32'(frame_count), 32'd1);
        layer_pooling_done = 1'b0;
        chk("a_sb_empty", 32'(sb.size()), 32'd0);

        // Frame B: upstream bubble; start during DONE is ignored
        exact_mode = 1'b0;
        start_frame();
        feed(16, 100, 6);
        repeat (2) tick();
        layer_pooling_done = 1'b1;
        tick();
        chk("b_frame_done", 32'(frame_done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_done_pulse", 32'(frame_done), 32'd0);
        chk("b_idle_busy", 32'(busy), 32'd0);
        chk("b_count", 32'(frame_count), 32'd2);
        tick();
        chk("b_start_in_done_ignored", 32'(busy), 32'd0);
        layer_pooling_done = 1'b0;
        chk("b_sb_empty", 32'(sb.size()), 32'd0);

        // Frame C: stale high done level must not complete the frame
        exact_mode         = 1'b1;
        layer_pooling_done = 1'b1;
        start_frame();
        feed(16, 50, 0);
        repeat (5) begin
            chk("c_stale_no_done", 32'(frame_done), 32'd0);
            chk("c_stale_busy", 32'(busy), 32'd1);
            tick();
        end
        layer_pooling_done = 1'b0;
        tick();
        layer_pooling_done = 1'b1;
        chk("c_pre_done", 32'(frame_done), 32'd0);
        tick();
        chk("c_frame_done", 32'(frame_done), 32'd1);
        tick();
        chk("c_count", 32'(frame_count), 32'd3);
        layer_pooling_done = 1'b0;

        // Frame D: drain watchdog
        start_frame();
        feed(16, 200, 0);
        repeat (31) tick();
        chk("d_last_drain_error", 32'(error), 32'd0);
        chk("d_last_drain_busy", 32'(busy), 32'd1);
        tick();
        chk("d_error", 32'(error), 32'd1);
        chk("d_err_busy", 32'(busy), 32'd0);
        chk("d_err_ready", 32'(up_ready), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("d_start_ignored_busy", 32'(busy), 32'd0);
        chk("d_error_sticky", 32'(error), 32'd1);
        chk("d_count_hold", 32'(frame_count), 32'd3);

        // Reset out of ERR
        res_n = 1'b1;
        tick();
        res_n = 1'b0;
        chk("r_error", 32'(error), 32'd0);
        chk("r_count", 32'(frame_count), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);

        // Frame E: reset after 7 pixels
        start_frame();
        feed(7, 30, 0);
        res_n = 1'b1;
        tick();
        res_n = 1'b0;
        chk("e_in_valid", 32'(layer_in_valid), 32'd0);
        chk("e_in_data", 32'(layer_in_data), 32'd0);
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_ready", 32'(up_ready), 32'd0);
        chk("e_count", 32'(frame_count), 32'd0);
        chk("e_sb_empty", 32'(sb.size()), 32'd0);

        // Frame F: full frame after the mid-frame reset
        start_frame();
        feed(16, 0, 0);
        repeat (4) tick();
        layer_pooling_done = 1'b1;
        tick();
        chk("f_frame_done", 32'(frame_done), 32'd1);
        tick();
        chk("f_count", 32'(frame_count), 32'd1);
        layer_pooling_done = 1'b0;
        chk("f_sb_empty", 32'(sb.size()), 32'd0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
